// File: rtl/ifu_pkg.sv
// +--------------------------------------------------------------------------+
// | ifu_pkg : shared opcode constants, fetch-state encoding, length helper   |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package ifu_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDO = 4'b0001;
  localparam logic [3:0] OP_LDA = 4'b0010;
  localparam logic [3:0] OP_STO = 4'b0011;
  localparam logic [3:0] OP_HLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_FETCH_OP  = 2'd0,
    ST_FETCH_ARG = 2'd1,
    ST_HOLD      = 2'd2,
    ST_HALT      = 2'd3
  } ifu_state_t;

  function automatic logic is_two_byte(input logic [3:0] op);
    return (op == OP_LDO) || (op == OP_LDA) || (op == OP_STO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ins_len_dec.sv
// +--------------------------------------------------------------------------+
// | ins_len_dec : opcode -> instruction length / halt flags (combinational)  |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module ins_len_dec
  import ifu_pkg::*;
(
  input  logic [3:0] i_op,
  output logic       o_two_byte,
  output logic       o_is_hlt
);

  assign o_two_byte = is_two_byte(i_op);
  assign o_is_hlt   = (i_op == OP_HLT);

endmodule

`default_nettype wire

// File: rtl/ins_fetch.sv
// +--------------------------------------------------------------------------+
// | ins_fetch : PC owner and 1/2-byte instruction assembler with valid/ready |
// | Optional redirect port when IFU_JUMP_EN is defined.                      |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module ins_fetch
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_read,
  output logic              rom_ena,
  input  logic [DATA_W-1:0] rom_data,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [3:0]        ins_op,
  output logic [3:0]        ins_reg,
  output logic [7:0]        ins_arg,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              halted
`ifdef IFU_JUMP_EN
  ,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr
`endif
);

  ifu_state_t        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_ins_pc;
  logic [3:0]        r_op;
  logic [3:0]        r_reg;
  logic [7:0]        r_arg;
  logic              r_valid;
  logic              r_halted;

  logic [3:0]        w_dec_op;
  logic              w_two_byte;
  logic              w_is_hlt;
  logic              w_fetching;
  logic              w_jmp;
  logic [ADDR_W-1:0] w_jmp_addr;

`ifdef IFU_JUMP_EN
  assign w_jmp      = jmp_valid;
  assign w_jmp_addr = jmp_addr;
`else
  assign w_jmp      = 1'b0;
  assign w_jmp_addr = '0;
`endif

  // In HOLD the decoder looks at the held opcode (HLT test), otherwise at the ROM byte.
  assign w_dec_op = (r_state == ST_HOLD) ? r_op : rom_data[7:4];

  ins_len_dec u_len_dec (
    .i_op       (w_dec_op),
    .o_two_byte (w_two_byte),
    .o_is_hlt   (w_is_hlt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_FETCH_OP;
      r_pc     <= RESET_PC;
      r_ins_pc <= '0;
      r_op     <= '0;
      r_reg    <= '0;
      r_arg    <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else if (w_jmp) begin
      r_state  <= ST_FETCH_OP;
      r_pc     <= w_jmp_addr;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH_OP: begin
          r_op     <= rom_data[7:4];
          r_reg    <= rom_data[3:0];
          r_ins_pc <= r_pc;
          r_pc     <= r_pc + ADDR_W'(1);
          if (w_two_byte) begin
            r_state <= ST_FETCH_ARG;
          end else begin
            r_arg   <= '0;
            r_valid <= 1'b1;
            r_state <= ST_HOLD;
          end
        end
        ST_FETCH_ARG: begin
          r_arg   <= rom_data[7:0];
          r_pc    <= r_pc + ADDR_W'(1);
          r_valid <= 1'b1;
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (ins_ready) begin
            r_valid <= 1'b0;
            if (w_is_hlt) begin
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end else begin
              r_state  <= ST_FETCH_OP;
            end
          end
        end
        ST_HALT: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= ST_FETCH_OP;
        end
      endcase
    end
  end

  // Strobes are gated by rst_n so the ROM is idle for the whole reset window.
  assign w_fetching = rst_n && ((r_state == ST_FETCH_OP) || (r_state == ST_FETCH_ARG));

  assign rom_addr  = r_pc;
  assign rom_read  = w_fetching;
  assign rom_ena   = w_fetching;
  assign ins_valid = r_valid;
  assign ins_op    = r_op;
  assign ins_reg   = r_reg;
  assign ins_arg   = r_arg;
  assign ins_pc    = r_ins_pc;
  assign halted    = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_ins_fetch.sv
// +--------------------------------------------------------------------------+
// | tb_ins_fetch : directed bench with a transaction-level fetch model       |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ins_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rom_addr;
  logic       rom_read;
  logic       rom_ena;
  logic [7:0] rom_data;
  logic       ins_valid;
  logic       ins_ready;
  logic [3:0] ins_op;
  logic [3:0] ins_reg;
  logic [7:0] ins_arg;
  logic [7:0] ins_pc;
  logic       halted;
`ifdef IFU_JUMP_EN
  logic       jmp_valid;
  logic [7:0] jmp_addr;
`endif

  logic [7:0] rom [256];
  logic [3:0] ops [12] = '{4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA,
                           4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};

  int n_vec  = 0;
  int n_fail = 0;

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  ins_fetch #(
    .ADDR_W   (8),
    .DATA_W   (8),
    .RESET_PC (8'h00)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rom_addr  (rom_addr),
    .rom_read  (rom_read),
    .rom_ena   (rom_ena),
    .rom_data  (rom_data),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .ins_op    (ins_op),
    .ins_reg   (ins_reg),
    .ins_arg   (ins_arg),
    .ins_pc    (ins_pc),
    .halted    (halted)
`ifdef IFU_JUMP_EN
    ,
    .jmp_valid (jmp_valid),
    .jmp_addr  (jmp_addr)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic bit two_byte(input logic [3:0] op);
    return (op == 4'h1) || (op == 4'h2) || (op == 4'h3);
  endfunction

  // Model: which instruction is next, how many of its bytes are already read, halted or not.
  logic [7:0] m_pc      = 8'h00;
  int         m_fetched = 0;
  bit         m_halt    = 1'b0;
  logic       prev_rst_n = 1'b1;

  initial begin
    forever begin
      logic [7:0] b0;
      logic [7:0] exp_arg;
      int         len;
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_strobes", {rom_read, rom_ena}, 2'b00);
        if (!prev_rst_n)
          chk("rst_state", {ins_valid, halted, ins_op, ins_reg, ins_arg, ins_pc, rom_addr},
              {1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00});
        m_pc      = 8'h00;
        m_fetched = 0;
        m_halt    = 1'b0;
      end else begin
        b0      = rom[m_pc];
        len     = two_byte(b0[7:4]) ? 2 : 1;
        exp_arg = (len == 2) ? rom[8'(m_pc + 8'd1)] : 8'h00;
        if (m_halt) begin
          chk("halt_cycle", {ins_valid, halted, rom_read, rom_ena, rom_addr},
              {1'b0, 1'b1, 1'b0, 1'b0, m_pc});
        end else if (m_fetched < len) begin
          chk("fetch_cycle", {ins_valid, halted, rom_read, rom_ena, rom_addr},
              {1'b0, 1'b0, 1'b1, 1'b1, 8'(m_pc + 8'(m_fetched))});
          m_fetched++;
        end else begin
          chk("hold_cycle",
              {ins_valid, halted, rom_read, rom_ena, ins_op, ins_reg, ins_arg, ins_pc, rom_addr},
              {1'b1, 1'b0, 1'b0, 1'b0, b0[7:4], b0[3:0], exp_arg, m_pc, 8'(m_pc + 8'(len))});
          if (ins_ready) begin
            m_pc      = 8'(m_pc + 8'(len));
            m_fetched = 0;
            if (b0[7:4] == 4'h7) m_halt = 1'b1;
          end
        end
`ifdef IFU_JUMP_EN
        if (jmp_valid) begin
          m_pc      = jmp_addr;
          m_fetched = 0;
          m_halt    = 1'b0;
        end
`endif
      end
      prev_rst_n = rst_n;
    end
  end

  task automatic wait_rom(input logic [7:0] a, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rom_read && rom_addr == a) && n < 4000);
    chk(nm, {rom_read, rom_addr}, {1'b1, a});
  endtask

  task automatic wait_valid_pc(input logic [7:0] a, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ins_valid && ins_pc == a) && n < 4000);
    chk(nm, {ins_valid, ins_pc}, {1'b1, a});
  endtask

  task automatic wait_halted(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!halted && n < 4000);
    chk(nm, halted, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i;
    for (int k = 0; k < 256; k++) rom[k] = 8'h00;
    rom[1] = 8'h11; rom[2] = 8'h61;
    rom[3] = 8'h23; rom[4] = 8'hA5;
    rom[5] = 8'h4C;
    rom[6] = 8'h35; rom[7] = 8'h0F;
    rom[8] = 8'h52;
    for (int k = 9; k < 39; k++) rom[k] = {ops[k % 12], 4'(k)};
    rom[20] = 8'h17; rom[21] = 8'h64;
    rom[30] = 8'h2A; rom[31] = 8'h70;
    rom[39] = 8'h70;

    rst_n     = 1'b0;
    ins_ready = 1'b1;
`ifdef IFU_JUMP_EN
    jmp_valid = 1'b0;
    jmp_addr  = 8'h00;
`endif
    repeat (3) tick();
    rst_n = 1'b1;

    // NOP at 0, then LDO at 1 arrives two cycles after its fetch starts
    @(negedge clk); chk("first_fetch", {rom_read, rom_ena, rom_addr}, {1'b1, 1'b1, 8'h00});
    @(negedge clk); chk("nop_out", {ins_valid, ins_op, ins_pc, ins_arg}, {1'b1, 4'h0, 8'h00, 8'h00});
    @(negedge clk); chk("ldo_fetch_op", {ins_valid, rom_addr}, {1'b0, 8'h01});
    @(negedge clk); chk("ldo_fetch_arg", {ins_valid, rom_addr}, {1'b0, 8'h02});
    @(negedge clk); chk("ldo_out", {ins_valid, ins_op, ins_reg, ins_arg, ins_pc},
                        {1'b1, 4'h1, 4'h1, 8'h61, 8'h01});
    @(negedge clk); chk("after_ldo", {rom_read, rom_addr}, {1'b1, 8'h03});

    // stall on ROM[8]
    wait_rom(8'h08, "reach_8");
    tick();
    ins_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_8", {ins_valid, rom_read, rom_ena, ins_op, ins_reg, ins_arg, ins_pc, rom_addr},
          {1'b1, 1'b0, 1'b0, 4'h5, 4'h2, 8'h00, 8'h08, 8'h09});
    end
    tick();
    ins_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); chk("resume_9", {ins_valid, rom_read, rom_addr}, {1'b0, 1'b1, 8'h09});

    wait_valid_pc(8'd30, "lda_30");
    chk("lda_30_arg", {ins_op, ins_reg, ins_arg}, {4'h2, 4'hA, 8'h70});

    wait_halted("halt_39");
    repeat (20) begin
      @(negedge clk);
      chk("halt_hold", {halted, ins_valid, rom_read, rom_ena}, {1'b1, 1'b0, 1'b0, 1'b0});
    end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); chk("reset_after_halt", {halted, rom_addr}, {1'b0, 8'h00});

`ifdef IFU_JUMP_EN
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    jmp_valid = 1'b1;
    jmp_addr  = 8'd20;
    tick();
    jmp_valid = 1'b0;
    @(negedge clk); chk("jmp_fetch_20", {rom_read, rom_addr, ins_valid}, {1'b1, 8'd20, 1'b0});
    wait_valid_pc(8'd20, "jmp_ins_20");
    chk("jmp_ins_20_fields", {ins_op, ins_arg}, {4'h1, 8'h64});
    wait_halted("jmp_halt");
    tick();
    jmp_valid = 1'b1;
    tick();
    jmp_valid = 1'b0;
    @(negedge clk); chk("jmp_from_halt", {halted, rom_read, rom_addr}, {1'b0, 1'b1, 8'd20});
    tick();
    rst_n = 1'b0;
`endif

    // Second image: run the whole address space to exercise the wrap at 255
    rom[0]  = 8'h04;
    rom[39] = 8'h00;
    i = 40;
    while (i < 255) begin
      if (i % 10 == 0) begin
        rom[i]   = {4'(((i / 10) % 3) + 1), 4'(i)};
        rom[i+1] = 8'(i) ^ 8'h5A;
        i += 2;
      end else begin
        rom[i] = {ops[i % 12], 4'(i)};
        i++;
      end
    end
    rom[255] = 8'h36;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      tick();
      ins_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (ins_valid && ins_pc == 8'hFF) break;
    end
    chk("wrap_sto", {ins_valid, ins_op, ins_reg, ins_arg, ins_pc},
        {1'b1, 4'h3, 4'h6, 8'h04, 8'hFF});
    tick();
    ins_ready = 1'b1;
    wait_rom(8'h01, "wrap_next_1");

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ins_fetch.md
# ins_fetch

Instruction fetch unit for the 8-bit RISC CPU. Sits directly downstream of the program ROM and upstream of the control/execute unit. Owns the program counter, drives the ROM's address, read and enable lines, and assembles one- or two-byte instructions into a single held instruction word. That word is presented to the control unit with a valid/ready handshake.

## Interface
Parameters:
- ADDR_W, 8, PC / ROM address width
- DATA_W, 8, ROM data width
- RESET_PC, 8'h00, PC value after reset

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- rom_addr  output  ADDR_W  ROM address (= pc)
- rom_read  output  1  ROM read strobe
- rom_ena  output  1  ROM enable
- rom_data  input  DATA_W  ROM data, combinational from rom_addr; valid when rom_read && rom_ena
- ins_valid  output  1  held instruction valid
- ins_ready  input  1  control unit accepts instruction
- ins_op  output  4  opcode, byte0[7:4]
- ins_reg  output  4  register select, byte0[3:0]
- ins_arg  output  8  operand byte; 0 for one-byte instructions
- ins_pc  output  ADDR_W  address of byte0
- halted  output  1  HLT accepted; fetch stopped
- jmp_valid, jmp_addr  input  1 / ADDR_W  redirect (only with IFU_JUMP_EN)

## Operation
- Two-byte opcodes: 0001 LDO, 0010 LDA, 0011 STO. All other opcodes are one-byte. 0111 is HLT.
- States: FETCH_OP, FETCH_ARG, HOLD, HALT.
- FETCH_OP: rom_read = rom_ena = 1. At the edge, latch rom_data into byte0 (ins_op/ins_reg) and latch ins_pc <= pc, then pc <= pc+1.
  - Two-byte opcode: go to FETCH_ARG.
  - Otherwise: ins_arg <= 0, go to HOLD.
- FETCH_ARG: rom_read = rom_ena = 1. At the edge, ins_arg <= rom_data, pc <= pc+1, go to HOLD.
- HOLD: ins_valid = 1, rom_read = rom_ena = 0. All ins_* outputs are stable until accepted.
  - ins_valid && ins_ready: accepted. If ins_op = 0111, go to HALT; else go to FETCH_OP.
- HALT: halted = 1, ins_valid = 0, ROM strobes low. Held until reset (or jump).
- PC arithmetic is modulo 2^ADDR_W: 255+1 = 0. A two-byte opcode at 255 takes its operand from address 0.
- The unit never drops an instruction or re-fetches one while in HOLD.

## Timing
- Reset (rst_n = 0 at edge): state FETCH_OP, pc = RESET_PC, ins_valid = 0, ins_op = 0, ins_reg = 0, ins_arg = 0, ins_pc = 0, halted = 0.
- rom_read and rom_ena are 0 while rst_n = 0.
- Reset mid-instruction discards any partial fetch.
- One-byte instruction: ins_valid rises 1 cycle after entering FETCH_OP.
- Two-byte instruction: ins_valid rises 2 cycles after entering FETCH_OP.
- After acceptance, the next FETCH_OP is the following cycle. Peak throughput: 1 instruction per 2 cycles (one-byte) or per 3 cycles (two-byte).
- ins_ready may be high before ins_valid; it has no effect outside HOLD.
- rom_addr always equals pc, registered with no combinational path from ins_ready.

## Configuration
- IFU_JUMP_EN defined:
  - Adds jmp_valid and jmp_addr.
  - jmp_valid at an edge, in any state, gives pc <= jmp_addr, state FETCH_OP, ins_valid <= 0, halted <= 0.
  - Jump has priority over all transitions except reset.
  - In HOLD with ins_ready also high, the held instruction counts as accepted and the jump is still taken.
- IFU_JUMP_EN undefined: the ports are absent; behaviour is strictly sequential as described in Operation.

## Structure
- Shared package ifu_pkg holds:
  - opcode localparams (OP_NOP = 0000, OP_LDO = 0001, OP_LDA = 0010, OP_STO = 0011, OP_HLT = 0111)
  - state encoding (2 bits)
  - function is_two_byte(op)
- One sub-module: ins_len_dec, combinational, op -> two_byte and is_hlt flags. Shared later with the control unit.

## Test plan
- Reset with the ROM holding the program image; release rst_n. Cycle 1: rom_addr = 0, NOP fetched. Expect ins_valid, ins_op = 0, ins_pc = 0, ins_arg = 0.
- ROM[1] = 0001_0001, ROM[2] = 0110_0001, ins_ready = 1 → ins_op = 1, ins_reg = 1, ins_arg = 0x61, ins_pc = 1. ins_valid rises 2 cycles after FETCH_OP at pc 1. Next fetch is at pc 3.
- Hold ins_ready = 0 for 5 cycles on ROM[8] = 0101_0010 → ins_* stable, rom_read = rom_ena = 0, pc stays 9. Release ready → accepted once, then fetch at 9.
- ROM[39] = 0111_0000 accepted → halted = 1 next cycle, ins_valid = 0 and ROM strobes stay low for 20 cycles. Then rst_n low → pc = 0, halted = 0.
- Start pc at 255 with ROM[255] = 0011_0110 and ROM[0] = 0x04 → ins_arg = 0x04, ins_pc = 255, next fetch at 1.
- IFU_JUMP_EN: jmp_valid with jmp_addr = 20 asserted during FETCH_ARG → partial instruction discarded. Next FETCH_OP has rom_addr = 20; delivered ins_op = 0001, ins_arg = 0x64. Repeat the jump in HALT → halted = 0 and fetch resumes at 20.
